chroma_key_core: RTL
====================

# chroma_key_core

Streaming chroma-key pixel stage fed by the Avalon-MM register block of the chroma-key IP. It consumes the key colour, background colour and control word written by the Nios II and replaces every RGB888 pixel within tolerance of the key colour with the background colour. It returns a per-frame keyed-pixel count to the register block's software-readable status register through a write-enable port.

## Interface
Parameters:
- PIX_W, 24: pixel width, RGB888 packed as R[23:16] G[15:8] B[7:0].
- CNT_W, 32: keyed-pixel counter width.

Ports:
- clock  in  1  system clock, all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- cfg_key  in  32  key colour; [23:0] used, [31:24] ignored.
- cfg_bg  in  32  replacement colour; [23:0] used.
- cfg_ctrl  in  32  bit0 enable, bits[15:8] tolerance, others ignored.
- din_data  in  PIX_W  input pixel.
- din_valid  in  1  input pixel valid.
- din_sop  in  1  first pixel of frame.
- din_eop  in  1  last pixel of frame.
- din_ready  out  1  stage accepts input this cycle.
- dout_data  out  PIX_W  output pixel.
- dout_valid, dout_sop, dout_eop  out  1 each  output qualifiers.
- dout_ready  in  1  downstream accepts output.
- stat_data  out  CNT_W  keyed-pixel count of the finished frame.
- stat_we  out  1  one-cycle write strobe for stat_data.

## Operation
- Transfer occurs when valid and ready are both high on a rising edge. The input data and qualifiers must stay stable while valid is high and ready is low.
- Two-stage pipeline. The pipeline advances when adv = ~s2_valid | dout_ready, and din_ready = adv.
- Stage 1: registers the pixel, sop/eop, and the three per-channel absolute differences |pix_c − key_c| (8-bit, unsigned).
- Stage 2: keyed = enable & all three differences ≤ tolerance. Output is cfg_bg[23:0] if keyed, else the pixel. sop/eop pass through unchanged.
- cfg_key, cfg_bg and tolerance/enable are latched into shadow registers when a pixel with din_sop is accepted. They are held for the whole frame, so mid-frame register writes take effect at the next sop. The shadow registers reset to 0 with enable = 0 (pass-through).
- Tolerance 0 keys exact matches only. Tolerance 255 keys every pixel when enabled.
- Keyed counter: increments on each output transfer with keyed = 1 and saturates at 2^CNT_W−1.
  - On an output transfer with eop: stat_data = count including that pixel, stat_we = 1 for the next cycle, and the counter clears to 0.
  - A pixel with sop accepted without a prior eop does not clear the counter. Frames are delimited by eop only.
- Pixels with sop and eop in the same beat form a 1-pixel frame and are handled normally.

## Timing
- Latency: 2 cycles from input transfer to dout_valid when unstalled. Throughput is 1 pixel/cycle.
- Backpressure: dout_ready low holds stage 2. Stage 1 and din_ready also stall while s2_valid is high. There are no bubbles on a continuous stream.
- stat_we rises on the cycle after the eop output transfer and is high for exactly 1 cycle. stat_data holds its value until the next frame's update.
- Reset values: din_ready 1 in the cycle after reset. dout_valid/sop/eop 0, dout_data 0, stat_we 0, stat_data 0, counter 0, both pipeline valids 0.
- Reset mid-frame discards in-flight pixels and the partial count. No stat_we is issued.

## Configuration
- CHROMA_KEY_STATS_EN defined: the keyed-pixel counter, stat_data and stat_we are implemented as above.
- Not defined: there is no counter logic, stat_data is tied to 0, and stat_we is tied to 0. The pixel path is unchanged.

## Structure
- Package chroma_key_pkg holds the following:
  - pixel typedef (R/G/B 8-bit fields)
  - CTRL_EN_BIT = 0
  - CTRL_TOL_LSB = 8 and CTRL_TOL_MSB = 15
  - default PIX_W/CNT_W constants
- Sub-module chroma_key_diff: combinational per-channel absolute difference of two RGB888 values. It is instantiated once in stage 1.

## Test plan
- Enable 1, key 0x00FF00, tol 0x10, bg 0x0000FF. Pixels 0x08F008 and 0x20FF00 → outputs 0x0000FF and 0x20FF00 two cycles after input.
- Enable 0, any key. A 4-pixel frame → output bit-identical to input, and stat_data = 0 with one stat_we pulse after eop.
- 16-pixel frame, 5 matching pixels, dout_ready toggling 1010… → no pixel lost or duplicated, ordering kept, stat_data = 5 written once.
- Write a new cfg_key in the middle of frame N → frame N uses the old key and frame N+1 uses the new key.
- 1-pixel frame (sop = eop = 1) that matches → stat_we pulse with stat_data = 1, and the next frame's count starts at 0.
- Assert reset with 2 pixels in flight → dout_valid 0 the next cycle, no stat_we, and the following frame counts from 0.

Source files
------------

// File: rtl/chroma_key_pkg.sv
// Shared types and constants for the chroma-key pixel stage.
package chroma_key_pkg;

  localparam int unsigned DEF_PIX_W = 24;
  localparam int unsigned DEF_CNT_W = 32;

  // Control word layout.
  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_TOL_LSB = 8;
  localparam int unsigned CTRL_TOL_MSB = 15;

  // RGB888 packed as R[23:16] G[15:8] B[7:0].
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  function automatic logic [7:0] abs_diff8(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/chroma_key_diff.sv
// Combinational per-channel absolute difference of two RGB888 values.
module chroma_key_diff
  import chroma_key_pkg::*;
(
  input  logic [23:0] pix,
  input  logic [23:0] key,
  output logic [7:0]  diff_r,
  output logic [7:0]  diff_g,
  output logic [7:0]  diff_b
);

  pixel_t p;
  pixel_t k;

  assign p = pixel_t'(pix);
  assign k = pixel_t'(key);

  // Unsigned |pix_c - key_c| for each channel.
  always_comb begin
    diff_r = abs_diff8(p.r, k.r);
    diff_g = abs_diff8(p.g, k.g);
    diff_b = abs_diff8(p.b, k.b);
  end

endmodule

// File: rtl/chroma_key_core.sv
// Two-stage streaming chroma-key stage: pixels close to the key colour are replaced
// by the background colour. Optional per-frame keyed-pixel statistics are built when
// CHROMA_KEY_STATS_EN is defined; otherwise stat_data/stat_we are tied to 0.
module chroma_key_core
  import chroma_key_pkg::*;
#(
  parameter int unsigned PIX_W = DEF_PIX_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      cfg_key,
  input  logic [31:0]      cfg_bg,
  input  logic [31:0]      cfg_ctrl,
  input  logic [PIX_W-1:0] din_data,
  input  logic             din_valid,
  input  logic             din_sop,
  input  logic             din_eop,
  output logic             din_ready,
  output logic [PIX_W-1:0] dout_data,
  output logic             dout_valid,
  output logic             dout_sop,
  output logic             dout_eop,
  input  logic             dout_ready,
  output logic [CNT_W-1:0] stat_data,
  output logic             stat_we
);

  logic             adv;
  logic             s2_valid;
  logic [PIX_W-1:0] s2_data;
  logic             s2_sop;
  logic             s2_eop;

  // Per-frame shadow configuration.
  logic [23:0] sh_key;
  logic [23:0] sh_bg;
  logic [7:0]  sh_tol;
  logic        sh_en;

  // Configuration that applies to the pixel currently at the input.
  logic [23:0] sel_key;
  logic [23:0] sel_bg;
  logic [7:0]  sel_tol;
  logic        sel_en;

  logic [7:0] d_r;
  logic [7:0] d_g;
  logic [7:0] d_b;

  logic             s1_valid;
  logic [PIX_W-1:0] s1_pix;
  logic             s1_sop;
  logic             s1_eop;
  logic [7:0]       s1_dr;
  logic [7:0]       s1_dg;
  logic [7:0]       s1_db;
  logic [PIX_W-1:0] s1_bg;
  logic [7:0]       s1_tol;
  logic             s1_en;
  logic             s1_keyed;

  logic unused_cfg;
  assign unused_cfg = ^{cfg_key[31:24], cfg_bg[31:24], cfg_ctrl[31:16], cfg_ctrl[7:1]};

  assign adv       = ~s2_valid | dout_ready;
  assign din_ready = adv;

  // A sop pixel starts a new frame, so it already sees the freshly written registers.
  always_comb begin
    sel_key = sh_key;
    sel_bg  = sh_bg;
    sel_tol = sh_tol;
    sel_en  = sh_en;
    if (din_sop) begin
      sel_key = cfg_key[23:0];
      sel_bg  = cfg_bg[23:0];
      sel_tol = cfg_ctrl[CTRL_TOL_MSB:CTRL_TOL_LSB];
      sel_en  = cfg_ctrl[CTRL_EN_BIT];
    end
  end

  chroma_key_diff u_diff (
    .pix    (din_data[23:0]),
    .key    (sel_key),
    .diff_r (d_r),
    .diff_g (d_g),
    .diff_b (d_b)
  );

  // Latch the frame configuration when a sop pixel is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      sh_key <= '0;
      sh_bg  <= '0;
      sh_tol <= '0;
      sh_en  <= 1'b0;
    end else if (din_valid && adv && din_sop) begin
      sh_key <= sel_key;
      sh_bg  <= sel_bg;
      sh_tol <= sel_tol;
      sh_en  <= sel_en;
    end
  end

  // Stage 1: register pixel, qualifiers, channel differences and the pixel's frame config.
  // Carrying the config per pixel keeps the previous frame's tail keyed with its own settings.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_pix   <= '0;
      s1_sop   <= 1'b0;
      s1_eop   <= 1'b0;
      s1_dr    <= '0;
      s1_dg    <= '0;
      s1_db    <= '0;
      s1_bg    <= '0;
      s1_tol   <= '0;
      s1_en    <= 1'b0;
    end else if (adv) begin
      s1_valid <= din_valid;
      s1_pix   <= din_data;
      s1_sop   <= din_sop;
      s1_eop   <= din_eop;
      s1_dr    <= d_r;
      s1_dg    <= d_g;
      s1_db    <= d_b;
      s1_bg    <= PIX_W'(sel_bg);
      s1_tol   <= sel_tol;
      s1_en    <= sel_en;
    end
  end

  assign s1_keyed = s1_en & (s1_dr <= s1_tol) & (s1_dg <= s1_tol) & (s1_db <= s1_tol);

  // Stage 2: registered output with background substitution.
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_sop   <= 1'b0;
      s2_eop   <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_data  <= s1_keyed ? s1_bg : s1_pix;
      s2_sop   <= s1_sop;
      s2_eop   <= s1_eop;
    end
  end

  assign dout_valid = s2_valid;
  assign dout_data  = s2_data;
  assign dout_sop   = s2_sop;
  assign dout_eop   = s2_eop;

`ifdef CHROMA_KEY_STATS_EN
  logic             s2_keyed;
  logic             out_xfer;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] stat_q;
  logic             stat_we_q;

  assign out_xfer = s2_valid & dout_ready;

  // Keyed flag travels alongside the stage-2 pixel.
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_keyed <= 1'b0;
    end else if (adv) begin
      s2_keyed <= s1_valid & s1_keyed;
    end
  end

  // Saturating count including the pixel now leaving stage 2.
  always_comb begin
    cnt_next = cnt_q;
    if (s2_keyed && (cnt_q != '1)) begin
      cnt_next = cnt_q + CNT_W'(1);
    end
  end

  // Count keyed output transfers; publish and clear on the eop transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      stat_q    <= '0;
      stat_we_q <= 1'b0;
    end else begin
      stat_we_q <= 1'b0;
      if (out_xfer) begin
        if (s2_eop) begin
          stat_q    <= cnt_next;
          stat_we_q <= 1'b1;
          cnt_q     <= '0;
        end else begin
          cnt_q <= cnt_next;
        end
      end
    end
  end

  assign stat_data = stat_q;
  assign stat_we   = stat_we_q;
`else
  assign stat_data = '0;
  assign stat_we   = 1'b0;
`endif

endmodule
